// File: rtl/adder_stream_ctrl.sv
// Operand-table sequencer and result checker for an adder-class DUT.
// Streams preloaded (a,b) pairs and scores DUT results against (a+b) mod 2^WIDTH.
module adder_stream_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned RES_LAT = 1,
  parameter int unsigned ERR_W   = 16,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ld_valid_i,
  output logic             ld_ready_o,
  input  logic [WIDTH-1:0] ld_a_i,
  input  logic [WIDTH-1:0] ld_b_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [AW:0]      count_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             op_valid_o,
  input  logic [WIDTH-1:0] res_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [AW:0]      fill_o,
  output logic [31:0]      vec_cnt_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0] last_a_o,
  output logic [WIDTH-1:0] last_b_o,
  output logic [WIDTH-1:0] last_res_o
);

  typedef enum logic [1:0] {StIdle, StPlay, StDrain, StDone} state_e;
  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] idx_t;

  state_e           r_state, w_state_d;
  cnt_t             r_fill, r_n, w_n;
  idx_t             r_idx, w_idx_d;
  logic             r_mode, r_op_valid, r_done;
  logic [WIDTH-1:0] r_a, r_b;
  logic [31:0]      r_vec_cnt;
  logic [ERR_W-1:0] r_err_cnt;
  logic [WIDTH-1:0] r_last_a, r_last_b, r_last_res;
  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];

  // Check pipeline: stage RES_LAT-1 lines up with res_i.
  logic [RES_LAT-1:0] r_pv;
  logic [WIDTH-1:0]   r_pa [RES_LAT];
  logic [WIDTH-1:0]   r_pb [RES_LAT];

  logic             w_start, w_issue, w_last, w_ld_fire, w_mismatch;
  logic [WIDTH-1:0] w_exp;

  assign ld_ready_o = !reset_i && (r_state == StIdle || r_state == StDone) &&
                      (r_fill < cnt_t'(DEPTH));
  assign w_ld_fire  = ld_valid_i && ld_ready_o;
  assign w_n        = (count_i > r_fill) ? r_fill : count_i;
  assign w_last     = ({1'b0, r_idx} == (r_n - cnt_t'(1)));
  assign w_exp      = r_pa[RES_LAT-1] + r_pb[RES_LAT-1];
  assign w_mismatch = (w_exp != res_i);

  always_comb begin
    w_state_d = r_state;
    w_start   = 1'b0;
    w_issue   = 1'b0;
    w_idx_d   = r_idx;
    unique case (r_state)
      StIdle, StDone: begin
        if (start_i) begin
          w_state_d = StPlay;
          w_start   = 1'b1;
        end
      end
      StPlay: begin
        // The vector on a_o this cycle is already issued; abort only stops the next one.
        if (r_n == '0 || abort_i || (w_last && !r_mode)) begin
          w_state_d = StDrain;
        end else begin
          w_issue = 1'b1;
          w_idx_d = w_last ? '0 : r_idx + idx_t'(1);
        end
      end
      StDrain: begin
        if (r_pv == '0) w_state_d = StDone;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_ld_fire) begin
      r_mem_a[r_fill[AW-1:0]] <= ld_a_i;
      r_mem_b[r_fill[AW-1:0]] <= ld_b_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= StIdle;
      r_fill     <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_mode     <= 1'b0;
      r_op_valid <= 1'b0;
      r_done     <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_vec_cnt  <= '0;
      r_err_cnt  <= '0;
      r_last_a   <= '0;
      r_last_b   <= '0;
      r_last_res <= '0;
      r_pv       <= '0;
      for (int i = 0; i < RES_LAT; i++) begin
        r_pa[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      if (w_ld_fire) r_fill <= r_fill + cnt_t'(1);

      if (w_start) begin
        r_mode     <= mode_i;
        r_n        <= w_n;
        r_idx      <= '0;
        r_vec_cnt  <= '0;
        r_err_cnt  <= '0;
        r_done     <= 1'b0;
        r_op_valid <= (w_n != '0);
        if (w_n != '0) begin
          r_a <= r_mem_a[0];
          r_b <= r_mem_b[0];
        end
      end else if (w_issue) begin
        r_idx      <= w_idx_d;
        r_a        <= r_mem_a[w_idx_d];
        r_b        <= r_mem_b[w_idx_d];
        r_op_valid <= 1'b1;
      end else begin
        r_op_valid <= 1'b0;
      end

      if (r_state == StDrain && w_state_d == StDone) r_done <= 1'b1;

      r_pv[0] <= r_op_valid;
      r_pa[0] <= r_a;
      r_pb[0] <= r_b;
      for (int i = 1; i < RES_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
      end

      if (r_pv[RES_LAT-1]) begin
        r_vec_cnt  <= r_vec_cnt + 32'd1;
        r_last_a   <= r_pa[RES_LAT-1];
        r_last_b   <= r_pb[RES_LAT-1];
        r_last_res <= res_i;
        if (w_mismatch && r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign a_o        = r_a;
  assign b_o        = r_b;
  assign op_valid_o = r_op_valid;
  assign busy_o     = (r_state == StPlay) || (r_state == StDrain);
  assign done_o     = r_done;
  assign fill_o     = r_fill;
  assign vec_cnt_o  = r_vec_cnt;
  assign err_cnt_o  = r_err_cnt;
  assign last_a_o   = r_last_a;
  assign last_b_o   = r_last_b;
  assign last_res_o = r_last_res;

endmodule

// File: tb/tb_adder_stream_ctrl.sv
// Bench for adder_stream_ctrl: two instances (RES_LAT 1 and 3) share stimulus, each
// driven by its own behavioural adder; issued operands are scoreboarded.
module tb_adder_stream_ctrl;
  localparam int unsigned AW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i = 1'b1, ld_valid = 1'b0, start = 1'b0, mode = 1'b0;
  logic          abort = 1'b0, inject = 1'b0;
  logic [7:0]    ld_a = '0, ld_b = '0;
  logic [AW:0]   count = '0;

  logic          ld_ready1, op1, busy1, done1, ld_ready3, op3, busy3, done3;
  logic [7:0]    a1, b1, res1, la1, lb1, lr1, a3, b3, res3, la3, lb3, lr3;
  logic [AW:0]   fill1, fill3;
  logic [31:0]   vec1, vec3;
  logic [15:0]   err1, err3;
  logic [7:0]    p3_0, p3_1, p3_2;

  adder_stream_ctrl #(.WIDTH(8), .DEPTH(2048), .RES_LAT(1), .ERR_W(16)) u_dut1 (
    .clk_i(clk), .reset_i(reset_i), .ld_valid_i(ld_valid), .ld_ready_o(ld_ready1),
    .ld_a_i(ld_a), .ld_b_i(ld_b), .start_i(start), .mode_i(mode), .count_i(count),
    .abort_i(abort), .a_o(a1), .b_o(b1), .op_valid_o(op1), .res_i(res1),
    .busy_o(busy1), .done_o(done1), .fill_o(fill1), .vec_cnt_o(vec1), .err_cnt_o(err1),
    .last_a_o(la1), .last_b_o(lb1), .last_res_o(lr1)
  );

  adder_stream_ctrl #(.WIDTH(8), .DEPTH(2048), .RES_LAT(3), .ERR_W(16)) u_dut3 (
    .clk_i(clk), .reset_i(reset_i), .ld_valid_i(ld_valid), .ld_ready_o(ld_ready3),
    .ld_a_i(ld_a), .ld_b_i(ld_b), .start_i(start), .mode_i(mode), .count_i(count),
    .abort_i(abort), .a_o(a3), .b_o(b3), .op_valid_o(op3), .res_i(res3),
    .busy_o(busy3), .done_o(done3), .fill_o(fill3), .vec_cnt_o(vec3), .err_cnt_o(err3),
    .last_a_o(la3), .last_b_o(lb3), .last_res_o(lr3)
  );

  // Adder DUT models; inject adds 1 to the (100,27) result.
  always @(posedge clk) begin
    res1 <= a1 + b1 + {7'd0, inject && a1 == 8'd100 && b1 == 8'd27};
    p3_0 <= a3 + b3 + {7'd0, inject && a3 == 8'd100 && b3 == 8'd27};
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign res3 = p3_2;

  int          n_checks = 0, n_fail = 0, n_ops = 0, ops0;
  logic [15:0] exp_q [$];
  logic [7:0]  ta [4] = '{8'd1, 8'd255, 8'd100, 8'd0};
  logic [7:0]  tbv [4] = '{8'd2, 8'd1, 8'd27, 8'd0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_idx(input int i);
    exp_q.push_back({ta[i], tbv[i]});
  endtask

  task automatic load_pair(input logic [7:0] a, input logic [7:0] b);
    ld_valid = 1'b1; ld_a = a; ld_b = b;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic start_play(input logic m, input int c);
    mode = m; count = (AW+1)'(c); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!(done1 === 1'b1 && done3 === 1'b1) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, ".done"}, {30'd0, done1, done3}, 32'd3);
  endtask

  task automatic chk_status(input string tag, input int vec, input int err,
                            input int la, input int lb, input int lr);
    chk({tag, ".vec1"}, vec1, vec);        chk({tag, ".vec3"}, vec3, vec);
    chk({tag, ".err1"}, {16'd0, err1}, err); chk({tag, ".err3"}, {16'd0, err3}, err);
    chk({tag, ".last1"}, {8'd0, la1, lb1, lr1}, {8'd0, la[7:0], lb[7:0], lr[7:0]});
    chk({tag, ".last3"}, {8'd0, la3, lb3, lr3}, {8'd0, la[7:0], lb[7:0], lr[7:0]});
    chk({tag, ".busy"}, {30'd0, busy1, busy3}, 32'd0);
    chk({tag, ".ops"}, n_ops - ops0, exp_q.size() == 0 ? n_ops - ops0 : -1);
    chk({tag, ".queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    // Operand monitor: every issued pair must match the next expected entry.
    fork
      forever begin
        @(negedge clk);
        if (op1 === 1'b1 || op3 === 1'b1) begin
          n_ops++;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_op: got a=%0d b=%0d expected no issue", a1, b1);
          end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            chk("op1", {15'd0, op1, a1, b1}, {15'd0, 1'b1, e});
            chk("op3", {15'd0, op3, a3, b3}, {15'd0, 1'b1, e});
          end
        end
      end
    join_none

    @(posedge clk); #1;
    chk("rst.ctrl", {ld_ready1, op1, busy1, done1, ld_ready3, op3, busy3, done3}, 32'd0);
    chk("rst.fill", {fill1, fill3}, 32'd0);
    reset_i = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) load_pair(ta[i], tbv[i]);
    chk("load4.fill", {fill1, fill3}, {8'd0, 12'd4, 12'd4});

    // One-shot, correct adder
    for (int i = 0; i < 4; i++) push_idx(i);
    ops0 = n_ops;
    start_play(1'b0, 4);
    chk("play.ld_ready", {ld_ready1, ld_ready3}, 32'd0);
    wait_done("oneshot");
    chk("oneshot.ops", n_ops - ops0, 4);
    chk_status("oneshot", 4, 0, 0, 0, 0);

    // Corrupted result on (100,27)
    inject = 1'b1;
    for (int i = 0; i < 4; i++) push_idx(i);
    ops0 = n_ops;
    start_play(1'b0, 4);
    wait_done("inject");
    inject = 1'b0;
    chk("inject.ops", n_ops - ops0, 4);
    chk_status("inject", 4, 1, 0, 0, 0);

    // Count clamped to fill
    for (int i = 0; i < 4; i++) push_idx(i);
    ops0 = n_ops;
    start_play(1'b0, 10);
    wait_done("clamp");
    chk("clamp.ops", n_ops - ops0, 4);
    chk_status("clamp", 4, 0, 0, 0, 0);

    // Zero count: done within RES_LAT+2 cycles, nothing issued
    ops0 = n_ops;
    start_play(1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("zero.done1", {31'd0, done1}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("zero.done3", {31'd0, done3}, 32'd1);
    chk("zero.ops", n_ops - ops0, 0);
    chk("zero.vec", vec1 + vec3, 0);

    // Loop over 3 entries, abort on the 7th issued vector
    for (int k = 0; k < 7; k++) push_idx(k % 3);
    ops0 = n_ops;
    start_play(1'b1, 3);
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done("loop");
    chk("loop.ops", n_ops - ops0, 7);
    chk_status("loop", 7, 0, 1, 2, 3);

    // Reset mid-play
    for (int i = 0; i < 3; i++) push_idx(i);
    ops0 = n_ops;
    start_play(1'b1, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    chk("midrst.ctrl", {op1, busy1, done1, op3, busy3, done3}, 32'd0);
    chk("midrst.fill", {fill1, fill3}, 32'd0);
    chk("midrst.cnt", vec1 | vec3 | {16'd0, err1 | err3}, 32'd0);
    chk("midrst.last", {la1, lb1, lr1, la3} | {8'd0, lb3, lr3, 8'd0}, 32'd0);
    chk("midrst.ops", n_ops - ops0, 3);

    // Fill the table completely
    ld_valid = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      ld_a = 8'(i); ld_b = ~8'(i);
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    chk("full.fill", {fill1, fill3}, {8'd0, 12'd2048, 12'd2048});
    chk("full.ld_ready", {ld_ready1, ld_ready3}, 32'd0);
    load_pair(8'hAA, 8'h55);
    chk("full.extra", {fill1, fill3}, {8'd0, 12'd2048, 12'd2048});

    exp_q.push_back({8'd0, 8'd255});
    exp_q.push_back({8'd1, 8'd254});
    ops0 = n_ops;
    start_play(1'b0, 2);
    wait_done("full");
    chk("full.ops", n_ops - ops0, 2);
    chk_status("full", 2, 0, 1, 254, 255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
